// File: rtl/rx_serial_7o1_if.sv
// Bus between the 7O1 serial receiver and its user: serial input, clear
// request, and the received character with its status flags.
interface rx_serial_7o1_if;
  logic       dado_serial;
  logic       limpa;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_parada;
  logic [3:0] db_estado;

  // Driver side: owns the line and the clear request
  modport master (
    output dado_serial, limpa,
    input  dados_ascii, pronto, tem_dado, erro_paridade, erro_parada, db_estado
  );

  // Receiver side
  modport slave (
    input  dado_serial, limpa,
    output dados_ascii, pronto, tem_dado, erro_paridade, erro_parada, db_estado
  );
endinterface

// File: rtl/rx_serial_7o1.sv
// Asynchronous serial receiver, 7O1 frames (start, 7 data LSB first, odd
// parity, stop). M clock cycles per bit; N bits for the bit-time counter.
// Optional macro RX_PARITY_CHECK_EN: when defined, a parity error rejects the
// frame and raises erro_paridade; otherwise parity is sampled but ignored.
module rx_serial_7o1 #(
  parameter int unsigned M = 434,
  parameter int unsigned N = 9
) (
  input logic            clock,
  input logic            reset,
  rx_serial_7o1_if.slave bus
);

  localparam logic [N-1:0] HALF_LAST = N'(M / 2 - 1);
  localparam logic [N-1:0] BIT_LAST  = N'(M - 1);

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'd0,
    ST_START    = 4'd1,
    ST_DADOS    = 4'd2,
    ST_PARIDADE = 4'd3,
    ST_PARADA   = 4'd4,
    ST_FINAL    = 4'd5,
    ST_ESPERA   = 4'd6
  } state_t;

  state_t       state;
  logic         sync1;
  logic         s_rx;
  logic [N-1:0] cnt;
  logic [2:0]   nbits;
  logic [6:0]   shreg;
  logic         stop_bit;
  logic         par_err;
  logic         frame_ok;

  logic [6:0]   dados_ascii;
  logic         pronto;
  logic         tem_dado;
  logic         erro_paridade;
  logic         erro_parada;

`ifdef RX_PARITY_CHECK_EN
  logic         par_bit;
  // Odd parity: data XOR parity must be 1
  assign par_err  = ~(^shreg ^ par_bit);
  assign frame_ok = stop_bit & ~par_err;
`else
  assign par_err  = 1'b0;
  assign frame_ok = stop_bit;
`endif

  // Two-flop synchronizer for the asynchronous line (idles high)
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      s_rx  <= 1'b1;
    end else begin
      sync1 <= bus.dado_serial;
      s_rx  <= sync1;
    end
  end

  // Frame FSM with bit-time counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_INICIAL;
      cnt           <= '0;
      nbits         <= '0;
      shreg         <= '0;
      stop_bit      <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      par_bit       <= 1'b0;
`endif
      dados_ascii   <= '0;
      pronto        <= 1'b0;
      tem_dado      <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      // Cleared first so that a good frame in the same cycle wins
      if (bus.limpa) tem_dado <= 1'b0;
      case (state)
        ST_INICIAL: begin
          cnt   <= '0;
          nbits <= '0;
          if (!s_rx) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= s_rx ? ST_INICIAL : ST_DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DADOS: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {s_rx, shreg[6:1]};
            nbits <= nbits + 1'b1;
            if (nbits == 3'd6) state <= ST_PARIDADE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARIDADE: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
`ifdef RX_PARITY_CHECK_EN
            par_bit <= s_rx;
`endif
            state <= ST_PARADA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARADA: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            stop_bit <= s_rx;
            state    <= ST_FINAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINAL: begin
          pronto        <= 1'b1;
          erro_paridade <= par_err;
          erro_parada   <= ~stop_bit;
          if (frame_ok) begin
            dados_ascii <= shreg;
            tem_dado    <= 1'b1;
          end
          state <= stop_bit ? ST_INICIAL : ST_ESPERA;
        end
        ST_ESPERA: begin
          if (s_rx) state <= ST_INICIAL;
        end
        default: state <= ST_INICIAL;
      endcase
    end
  end

  assign bus.dados_ascii   = dados_ascii;
  assign bus.pronto        = pronto;
  assign bus.tem_dado      = tem_dado;
  assign bus.erro_paridade = erro_paridade;
  assign bus.erro_parada   = erro_parada;
  assign bus.db_estado     = state;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1 with M = 8, N = 4: directed frames, a frame-level
// model predicting when pronto fires and what the flags hold afterwards.
module tb_rx_serial_7o1;

  localparam int M = 8;
  localparam int PRONTO_OFS = 3 + M / 2 + 9 * M;

  typedef struct {
    int         at;
    logic [6:0] d;
    bit         ok;
    bit         perr;
    bit         serr;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_c0 = 0;
  logic limpa_seen = 1'b0;
  logic reset_seen = 1'b0;

  ev_t  evq[$];
  int   pcyc[$];

  logic [6:0] m_d = '0;
  logic       m_tem = 1'b0;
  logic       m_perr = 1'b0;
  logic       m_serr = 1'b0;
  logic       exp_p;

  rx_serial_7o1_if bus ();

  rx_serial_7o1 #(.M(M), .N(4)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    limpa_seen <= bus.limpa;
    reset_seen <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic odd_par(input logic [6:0] d);
    return ~^d;
  endfunction

  // Sends one frame; cut > 0 aborts it with a reset after that many cycles;
  // limpa_end raises limpa exactly for the edge on which pronto is produced.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                            input int cut, input bit limpa_end);
    logic [9:0] bits;
    ev_t e;
    int  n;
    bits    = {s, p, d, 1'b0};
    last_c0 = cyc + 1;
    e.at    = last_c0 + PRONTO_OFS;
    e.d     = d;
`ifdef RX_PARITY_CHECK_EN
    e.perr  = ((^d) ^ p) != 1'b1;
`else
    e.perr  = 1'b0;
`endif
    e.serr  = !s;
    e.ok    = s && !e.perr;
    evq.push_back(e);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.dado_serial = bits[i];
      for (int j = 0; j < M; j++) begin
        if (cut != 0 && n == cut) begin
          bus.dado_serial = 1'b1;
          reset = 1'b1;
          tick(1);
          reset = 1'b0;
          return;
        end
        if (limpa_end && i == 9 && j == M - 1) bus.limpa = 1'b1;
        tick(1);
        n++;
      end
    end
    bus.limpa = 1'b0;
  endtask

  // Frame-level model and per-cycle compare
  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_p = 1'b0;
      if (reset_seen) begin
        m_d = '0; m_tem = 1'b0; m_perr = 1'b0; m_serr = 1'b0;
        evq.delete();
      end else begin
        if (limpa_seen) m_tem = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          exp_p  = 1'b1;
          m_perr = evq[0].perr;
          m_serr = evq[0].serr;
          if (evq[0].ok) begin
            m_d   = evq[0].d;
            m_tem = 1'b1;
          end
          void'(evq.pop_front());
        end
      end
      chk("pronto", 32'(bus.pronto), 32'(exp_p));
      chk("dados_ascii", 32'(bus.dados_ascii), 32'(m_d));
      chk("tem_dado", 32'(bus.tem_dado), 32'(m_tem));
      chk("erro_paridade", 32'(bus.erro_paridade), 32'(m_perr));
      chk("erro_parada", 32'(bus.erro_parada), 32'(m_serr));
      if (bus.pronto) pcyc.push_back(cyc);
    end
  end

  initial begin
    logic [6:0] msg [4];
    msg[0] = 7'h31; msg[1] = 7'h32; msg[2] = 7'h33; msg[3] = 7'h23;
    reset = 1'b1;
    bus.dado_serial = 1'b1;
    bus.limpa = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("reset_db_estado", 32'(bus.db_estado), 32'd0);
    chk("reset_tem_dado", 32'(bus.tem_dado), 32'd0);

    // Good frame '5'
    send_frame(7'h35, 1'b1, 1'b1, 0, 1'b0);
    tick(1);
    chk("pronto_latency", (pcyc.size() > 0) ? 32'(pcyc[$] - last_c0) : 32'hffff_ffff, 32'd79);
    chk("good_dados", 32'(bus.dados_ascii), 32'h35);
    chk("good_tem", 32'(bus.tem_dado), 32'd1);
    chk("good_errs", 32'({bus.erro_paridade, bus.erro_parada}), 32'd0);
    tick(2 * M);

    // Reset in the middle of the data bits
    send_frame(7'h36, odd_par(7'h36), 1'b1, 3 * M, 1'b0);
    chk("rst_db_estado", 32'(bus.db_estado), 32'd0);
    chk("rst_outputs", 32'({bus.dados_ascii, bus.pronto, bus.tem_dado,
                            bus.erro_paridade, bus.erro_parada}), 32'd0);
    tick(2 * M);
    send_frame(7'h33, 1'b1, 1'b1, 0, 1'b0);
    tick(1);
    chk("post_rst_dados", 32'(bus.dados_ascii), 32'h33);
    tick(2 * M);

    // Back-to-back message "123#"
    pcyc.delete();
    for (int k = 0; k < 4; k++) send_frame(msg[k], odd_par(msg[k]), 1'b1, 0, 1'b0);
    tick(1);
    chk("b2b_count", 32'(pcyc.size()), 32'd4);
    for (int k = 1; k < 4; k++)
      if (pcyc.size() > k) chk("b2b_spacing", 32'(pcyc[k] - pcyc[k-1]), 32'd80);
    chk("b2b_last", 32'(bus.dados_ascii), 32'h23);
    tick(2 * M);

    // Framing error, line held low afterwards
    send_frame(7'h35, 1'b1, 1'b0, 0, 1'b0);
    chk("frm_espera0", 32'(bus.db_estado), 32'd6);
    tick(20);
    chk("frm_espera1", 32'(bus.db_estado), 32'd6);
    chk("frm_erro_parada", 32'(bus.erro_parada), 32'd1);
    chk("frm_dados_kept", 32'(bus.dados_ascii), 32'h23);
    bus.dado_serial = 1'b1;
    tick(4);
    chk("frm_back_idle", 32'(bus.db_estado), 32'd0);
    tick(2 * M);
    send_frame(7'h35, 1'b1, 1'b1, 0, 1'b0);
    tick(1);
    chk("frm_recover", 32'(bus.dados_ascii), 32'h35);
    tick(2);

    // limpa alone
    bus.limpa = 1'b1;
    tick(1);
    bus.limpa = 1'b0;
    chk("limpa_alone", 32'(bus.tem_dado), 32'd0);
    tick(2 * M);

    // Parity error: 0x23 with parity bit 1
    send_frame(7'h23, 1'b1, 1'b1, 0, 1'b0);
    tick(1);
`ifdef RX_PARITY_CHECK_EN
    chk("par_flag", 32'(bus.erro_paridade), 32'd1);
    chk("par_dados_kept", 32'(bus.dados_ascii), 32'h35);
    chk("par_tem_kept", 32'(bus.tem_dado), 32'd0);
`else
    chk("par_flag", 32'(bus.erro_paridade), 32'd0);
    chk("par_dados", 32'(bus.dados_ascii), 32'h23);
    chk("par_tem", 32'(bus.tem_dado), 32'd1);
`endif
    tick(2 * M);

    // 3-cycle glitch is a false start
    bus.dado_serial = 1'b0;
    tick(3);
    bus.dado_serial = 1'b1;
    tick(12);
    chk("glitch_idle", 32'(bus.db_estado), 32'd0);
    tick(2 * M);

    // limpa in the same cycle as a good final
    send_frame(7'h37, 1'b0, 1'b1, 0, 1'b1);
    chk("collision_tem", 32'(bus.tem_dado), 32'd1);
    chk("collision_dados", 32'(bus.dados_ascii), 32'h37);
    tick(3);
    bus.limpa = 1'b1;
    tick(1);
    bus.limpa = 1'b0;
    chk("limpa_after", 32'(bus.tem_dado), 32'd0);
    chk("limpa_keeps_dados", 32'(bus.dados_ascii), 32'h37);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
